shared_mux_arbiter: RTL and testbench

//  Shares one output mux channel among N_REQ requesters. Each requester sends bursts on a

---
 rtl/shared_mux_arbiter_if.sv | 28 ++
 rtl/shared_mux_arbiter.sv | 120 ++++++++++++
 tb/tb_shared_mux_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mux_arbiter_if.sv
// Requester-side and consumer-side signals of the shared mux channel.
// The arbiter takes the slave view; whoever drives requests/ready takes the master view.
interface shared_mux_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic                  mode;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*DW-1:0]   req_data;
    logic [N_REQ-1:0]      req_last;
    logic [N_REQ-1:0]      gnt;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  out_ready;
    logic                  timeout_err;
    logic                  busy;

    modport master (
        output mode, req, req_data, req_last, out_ready,
        input  gnt, out_valid, out_data, out_last, timeout_err, busy
    );

    modport slave (
        input  mode, req, req_data, req_last, out_ready,
        output gnt, out_valid, out_data, out_last, timeout_err, busy
    );
endinterface

// File: rtl/shared_mux_arbiter.sv
// Burst-holding arbiter for one shared output channel: fixed-priority or round-robin
// selection, one-hot AND-OR output mux, and revocation of grants whose owner goes silent.
module shared_mux_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_mux_arbiter_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               to_q, to_d;

    logic [N_REQ-1:0]   fp_oh, rot, rot_oh, rr_oh;
    logic [2*N_REQ-1:0] req2, oh2;
    logic [PW-1:0]      rr_nxt;
    logic               own_req, xfer;

    logic [N_REQ-1:0][DW-1:0] lane_data;
    logic [DW-1:0]            mux_data;

    function automatic logic [N_REQ-1:0] lowest(input logic [N_REQ-1:0] v);
        return v & (~v + N_REQ'(1));
    endfunction

    // Round-robin: rotate req so rr_ptr sits at bit 0, take the lowest one, rotate back.
    always_comb begin
        fp_oh  = lowest(bus.req);
        req2   = {bus.req, bus.req} >> rr_ptr_q;
        rot    = req2[N_REQ-1:0];
        rot_oh = lowest(rot);
        oh2    = {rot_oh, rot_oh} << rr_ptr_q;
        rr_oh  = oh2[2*N_REQ-1:N_REQ];
        rr_nxt = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_oh[i]) rr_nxt = (i == N_REQ-1) ? '0 : PW'(i + 1);
        end
    end

    // Parallel select: each lane is masked by its own grant bit, then OR-reduced.
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign lane_data[g] = bus.req_data[g*DW +: DW] & {DW{gnt_q[g]}};
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_REQ; i++) mux_data |= lane_data[i];
    end

    assign own_req         = |(bus.req & gnt_q);
    assign xfer            = own_req && bus.out_ready;
    assign bus.gnt         = gnt_q;
    assign bus.out_valid   = own_req;
    assign bus.out_data    = mux_data;
    assign bus.out_last    = |(bus.req_last & gnt_q);
    assign bus.timeout_err = to_q;
    assign bus.busy        = (state_q == BUSY);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    hold_d  = '0;
                    gnt_d   = bus.mode ? rr_oh : fp_oh;
                    if (bus.mode) rr_ptr_d = rr_nxt;
                end
            end
            BUSY: begin
                // Backpressure with the owner still requesting leaves hold_q untouched.
                if (xfer) begin
                    hold_d = '0;
                    if (bus.out_last) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (!own_req) begin
                    if (hold_q == HW'(MAX_HOLD - 1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        to_d    = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
        end
    end
endmodule

// File: tb/tb_shared_mux_arbiter.sv
// Randomized scoreboard bench for shared_mux_arbiter against an integer-level ownership model.
module tb_shared_mux_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH = 16;
    localparam int PW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_mux_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    shared_mux_arbiter #(.N_REQ(N), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Per-requester beats {last, data}: src_q feeds the requester, exp_q is the scoreboard.
    logic [DW:0] src_q [N][$];
    logic [DW:0] exp_q [N][$];
    logic [N-1:0] acc = '0;
    logic [N-1:0] hold_off = '0;
    bit   rnd_drop = 1'b0;

    // Model: who owns the channel, where round-robin search starts, silent-owner run length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;
    bit m_to    = 1'b0;

    int checks = 0, errors = 0, to_seen = 0, xfers = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input bit rr, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = rr ? (ptr + k) % N : k;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic push_burst(input int i, input int len, input int base);
        for (int b = 0; b < len; b++) begin
            logic [DW:0] v;
            v = {(b == len - 1), DW'(base + b)};
            src_q[i].push_back(v);
            exp_q[i].push_back(v);
        end
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (bus.req != '0) begin
                m_owner = pick(bus.req, bus.mode, m_ptr);
                m_stall = 0;
                if (bus.mode) m_ptr = (m_owner + 1) % N;
            end
        end else if (bus.req[PW'(m_owner)]) begin
            if (bus.out_ready) begin
                if (bus.req_last[PW'(m_owner)]) m_owner = -1;
                else m_stall = 0;
            end
        end else begin
            m_stall++;
            if (m_stall == MH) begin
                m_owner = -1;
                m_to    = 1'b1;
            end
        end
    endtask

    task automatic drive();
        logic [N-1:0]    r, l;
        logic [N*DW-1:0] d;
        r = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && !hold_off[i] && !(rnd_drop && $urandom_range(9) == 0)) begin
                r[i]            = 1'b1;
                d[i*DW +: DW]   = src_q[i][0][DW-1:0];
                l[i]            = src_q[i][0][DW];
            end else begin
                d[i*DW +: DW]   = DW'($urandom);
                l[i]            = 1'($urandom);
            end
        end
        bus.req      = r;
        bus.req_data = d;
        bus.req_last = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        drive();
    endtask

    // Monitor: compares outputs against the model away from the clock edge and pops the
    // scoreboard on every accepted beat.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk) begin
                #1;
                chk("rst_gnt", bus.gnt, 0);
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_timeout", bus.timeout_err, 0);
            end else begin
                logic [N-1:0] eg;
                logic         ev;
                eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
                ev = (m_owner >= 0) && bus.req[PW'(m_owner)];
                chk("gnt", bus.gnt, eg);
                chk("busy", bus.busy, m_owner >= 0);
                chk("timeout_err", bus.timeout_err, m_to);
                chk("gnt_onehot0", $onehot0(bus.gnt), 1);
                chk("out_valid", bus.out_valid, ev);
                if (rst_n && bus.timeout_err) to_seen++;
                if (m_owner < 0) begin
                    chk("idle_out_data", bus.out_data, 0);
                    chk("idle_out_last", bus.out_last, 0);
                end else if (ev && bus.out_ready) begin
                    xfers++;
                    checks++;
                    if (exp_q[m_owner].size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard: beat from owner %0d data %0h with nothing expected at %0t",
                                 m_owner, bus.out_data, $time);
                    end else begin
                        logic [DW:0] e;
                        e = exp_q[m_owner].pop_front();
                        chk("out_data", bus.out_data, e[DW-1:0]);
                        chk("out_last", bus.out_last, e[DW]);
                    end
                end
                if (!rst_n) begin
                    acc = '0;
                    for (int i = 0; i < N; i++) exp_q[i].delete();
                end else begin
                    acc = bus.gnt & bus.req & {N{bus.out_ready}};
                end
            end
        end
    end

    initial begin
        int to0;
        bus.mode = 1'b0; bus.out_ready = 1'b0;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Fixed priority: 1 beats 3, then 3 after the bubble.
        bus.out_ready = 1'b1;
        push_burst(1, 1, 'h10);
        push_burst(3, 1, 'h30);
        repeat (8) tick();

        // Round-robin with everyone requesting: 0,1,2,3,0,... including the pointer wrap.
        bus.mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_burst(i, 1, 'h40 + i);
            push_burst(i, 1, 'h50 + i);
        end
        repeat (20) tick();

        // Three-beat burst under a 1,0,0,1,1 ready pattern, then a long backpressure stall.
        bus.mode = 1'b0;
        bus.out_ready = 1'b0;
        to0 = to_seen;
        push_burst(2, 3, 'hA1);
        repeat (2) tick();
        foreach (acc[k]) begin end
        bus.out_ready = 1'b1; tick();
        bus.out_ready = 1'b0; tick();
        bus.out_ready = 1'b0; tick();
        bus.out_ready = 1'b1; tick();
        bus.out_ready = 1'b1; tick();
        repeat (3) tick();
        push_burst(2, 2, 'hB1);
        bus.out_ready = 1'b0;
        repeat (24) tick();
        bus.out_ready = 1'b1;
        repeat (6) tick();
        chk("backpressure_no_timeout", to_seen - to0, 0);

        // Owner 0 goes silent after one beat: grant revoked, requester 1 takes over.
        to0 = to_seen;
        push_burst(0, 3, 'hC0);
        push_burst(1, 2, 'hD0);
        repeat (2) tick();
        hold_off[0] = 1'b1;
        repeat (26) tick();
        hold_off[0] = 1'b0;
        repeat (15) tick();
        chk("timeout_pulses", to_seen - to0, 1);

        // Reset in the middle of a round-robin burst, then arbitration restarts at index 0.
        bus.mode = 1'b1;
        push_burst(2, 1, 'hE0);
        push_burst(1, 6, 'hE8);
        repeat (4) tick();
        #1;
        rst_n = 1'b0;
        m_owner = -1; m_ptr = 0; m_stall = 0; m_to = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        tick();
        rst_n = 1'b1;
        push_burst(3, 1, 'hF3);
        push_burst(1, 1, 'hF1);
        repeat (8) tick();

        // Random traffic: burst lengths, ready, requester dropouts and mode flips mid-burst.
        rnd_drop = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (src_q[i].size() < 3 && $urandom_range(3) == 0)
                    push_burst(i, $urandom_range(1, 4), $urandom_range(255));
            bus.out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) bus.mode = ~bus.mode;
            tick();
        end

        rnd_drop = 1'b0;
        bus.out_ready = 1'b1;
        repeat (80) tick();
        for (int i = 0; i < N; i++) chk("drained", exp_q[i].size(), 0);
        chk("transfers_seen", (xfers > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
